norm_param_loader: RTL and testbench

- Write-side sequencer for the convolution normalization parameter RAM (distributed RAM, one WIDTH-bit word per address).
- Accepts packed parameter beats of LANES words each from the upstream DMA stream via a valid/ready handshake.
- Unpacks each beat and writes one word per cycle to consecutive RAM addresses starting at 0.
- Pulses load_done once the configured word count has been written; the compute path then reads the RAM.

---
 rtl/norm_param_loader.sv | 142 ++++++++++++++
 tb/tb_norm_param_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_param_loader.sv
// Purpose : unpacks LANES-word parameter beats from the DMA stream and writes them,
//           one word per cycle, to consecutive norm-parameter RAM addresses from 0.
// Latency : first RAM write 2 cycles after start (s_valid high); load_done the cycle after the last write.
// Backpressure: s_ready only in RECV; beats offered at any other time are held upstream.
//
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   start, word_count  - load request (IDLE only) and number of words to write
//   s_data/s_valid/s_ready - packed beat input handshake, lane 0 in the LSBs
//   ram_write_address/ram_input_data/ram_write_enable - distributed RAM write port
//   busy, load_done    - status: not IDLE, one-cycle completion pulse
module norm_param_loader #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 10,
  parameter int LANES     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_BITS:0]     word_count,
  input  logic [WIDTH*LANES-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [ADDR_BITS-1:0]   ram_write_address,
  output logic [WIDTH-1:0]       ram_input_data,
  output logic                   ram_write_enable,
  output logic                   busy,
  output logic                   load_done
);

  localparam int CNT_W  = ADDR_BITS + 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  // Full RAM depth; requests above this are clamped so the address never wraps.
  localparam logic [CNT_W-1:0]  MAX_WORDS = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [CNT_W-1:0]         written_q, written_d;
  logic [ADDR_BITS-1:0]     addr_q, addr_d;
  logic [LANE_W-1:0]        lane_q, lane_d;
  logic [WIDTH*LANES-1:0]   beat_q, beat_d;
  logic [WIDTH-1:0]         lane_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      written_q <= '0;
      addr_q    <= '0;
      lane_q    <= '0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      written_q <= written_d;
      addr_q    <= addr_d;
      lane_q    <= lane_d;
      beat_q    <= beat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    written_d = written_q;
    addr_d    = addr_q;
    lane_d    = lane_q;
    beat_d    = beat_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          count_d   = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
          written_d = '0;
          addr_d    = '0;
          lane_d    = '0;
          // An empty load still produces its completion pulse.
          state_d   = (word_count == '0) ? DONE : RECV;
        end
      end

      RECV: begin
        // s_ready is high throughout RECV, so s_valid alone completes the handshake.
        if (s_valid) begin
          beat_d  = s_data;
          lane_d  = '0;
          state_d = WRITE;
        end
      end

      WRITE: begin
        addr_d    = addr_q + ADDR_BITS'(1);
        written_d = written_q + CNT_W'(1);
        // Count reached: leftover lanes in the current beat are dropped.
        if (written_q + CNT_W'(1) == count_q) begin
          state_d = DONE;
        end else if (lane_q == LAST_LANE) begin
          state_d = RECV;
        end else begin
          lane_d = lane_q + LANE_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Lane select out of the captured beat.
  always_comb begin
    lane_word = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LANE_W'(i)) begin
        lane_word = beat_q[i*WIDTH +: WIDTH];
      end
    end
  end

  // Outputs decode from registered state only; the RAM bus is held at zero
  // outside WRITE so it is quiet between loads.
  assign s_ready           = (state_q == RECV);
  assign busy              = (state_q != IDLE);
  assign load_done         = (state_q == DONE);
  assign ram_write_enable  = (state_q == WRITE);
  assign ram_write_address = (state_q == WRITE) ? addr_q : '0;
  assign ram_input_data    = (state_q == WRITE) ? lane_word : '0;

endmodule

// File: tb/tb_norm_param_loader.sv
module tb_norm_param_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  word_count;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  ram_write_address;
  logic [31:0] ram_input_data;
  logic        ram_write_enable;
  logic        busy;
  logic        load_done;

  norm_param_loader #(.WIDTH(32), .ADDR_BITS(4), .LANES(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .word_count        (word_count),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .ram_write_address (ram_write_address),
    .ram_input_data    (ram_input_data),
    .ram_write_enable  (ram_write_enable),
    .busy              (busy),
    .load_done         (load_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: expected {addr, data} writes, and what the DUT actually wrote.
  logic [35:0] exp_q[$];
  logic [3:0]  obs_addr[$];
  logic [31:0] obs_data[$];

  int first_we, last_we, done_cyc, done_cnt, we_cnt, rdy_cnt, gap_rdy, taken;
  logic busy_at_done, busy_after, timed_out;

  function automatic logic [63:0] mk_beat(input int j);
    return {32'(2*j+2), 32'(2*j+1)};
  endfunction

  // Beat j carries words 2j+1 (lane 0) and 2j+2 (lane 1), so address i expects i+1.
  task automatic push_exp(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({4'(i), 32'(i+1)});
  endtask

  // Drives one load and records observations; cycle 1 is the cycle after start is taken.
  task automatic run_load(input logic [4:0] wc, input int nbeats, input int gap_cycles,
                          input int busy_start_cyc);
    int bi, gap_left;
    logic acc, seen;
    obs_addr.delete(); obs_data.delete();
    first_we = -1; last_we = -1; done_cyc = -1; done_cnt = 0; we_cnt = 0;
    rdy_cnt = 0; gap_rdy = 0; taken = 0; busy_at_done = 0; busy_after = 1; timed_out = 1;
    @(posedge clk); #1;
    start = 1; word_count = wc; s_valid = (nbeats > 0); s_data = mk_beat(0);
    bi = 0; gap_left = 0; acc = 0; seen = 0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      start = (c == busy_start_cyc);
      word_count = start ? 5'd1 : wc;
      if (acc) begin bi++; gap_left = gap_cycles; end
      if (gap_left > 0) begin s_valid = 0; gap_left--; end
      else s_valid = (bi < nbeats);
      s_data = mk_beat(bi);
      @(negedge clk);
      acc = s_ready && s_valid;
      if (acc) taken++;
      if (s_ready) rdy_cnt++;
      if (s_ready && !s_valid) gap_rdy++;
      if (ram_write_enable) begin
        we_cnt++;
        obs_addr.push_back(ram_write_address);
        obs_data.push_back(ram_input_data);
        if (first_we < 0) first_we = c;
        last_we = c;
      end
      if (load_done) done_cnt++;
      if (seen) begin busy_after = busy; timed_out = 0; break; end
      if (load_done) begin done_cyc = c; busy_at_done = busy; seen = 1; end
    end
    start = 0; s_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; word_count = 0; s_data = '0; s_valid = 0;
    #2;
    n_checks++;
    if ({s_ready, busy, ram_write_enable, load_done, ram_write_address, ram_input_data} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b busy=%b we=%b done=%b addr=%h data=%h want all 0",
               s_ready, busy, ram_write_enable, load_done, ram_write_address, ram_input_data);
    end
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    logic [35:0] e;
    push_exp(4);
    run_load(5'd4, 2, 0, -1);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got %b want 0", timed_out); end
    n_checks++; if (obs_addr.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_nwrites got %0d want %0d", obs_addr.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_addr.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({obs_addr[0], obs_data[0]} !== e) begin n_fail++; $display("FAIL basic_write got %h/%h want %h/%h", obs_addr[0], obs_data[0], e[35:32], e[31:0]); end
      void'(obs_addr.pop_front()); void'(obs_data.pop_front());
    end
    n_checks++; if (first_we != 2) begin n_fail++; $display("FAIL basic_first_write_cycle got %0d want 2", first_we); end
    n_checks++; if (we_cnt != 4 || last_we != 6) begin n_fail++; $display("FAIL basic_we_cycles got %0d (last %0d) want 4 (last 6)", we_cnt, last_we); end
    n_checks++; if (done_cyc != 7 || done_cnt != 1) begin n_fail++; $display("FAIL basic_done got cyc %0d cnt %0d want cyc 7 cnt 1", done_cyc, done_cnt); end
    n_checks++; if (busy_at_done !== 1'b1 || busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall got %b%b want 10", busy_at_done, busy_after); end
    n_checks++; if (taken != 2) begin n_fail++; $display("FAIL basic_beats got %0d want 2", taken); end
  endtask

  task automatic test_truncate();
    logic [35:0] e;
    push_exp(3);
    run_load(5'd3, 2, 0, -1);
    n_checks++; if (obs_addr.size() != 3) begin n_fail++; $display("FAIL trunc_nwrites got %0d want 3", obs_addr.size()); end
    while (exp_q.size() > 0 && obs_addr.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({obs_addr[0], obs_data[0]} !== e) begin n_fail++; $display("FAIL trunc_write got %h/%h want %h/%h", obs_addr[0], obs_data[0], e[35:32], e[31:0]); end
      void'(obs_addr.pop_front()); void'(obs_data.pop_front());
    end
    n_checks++; if (last_we != 5 || done_cyc != 6 || done_cnt != 1) begin n_fail++; $display("FAIL trunc_done got last %0d done %0d cnt %0d want 5 6 1", last_we, done_cyc, done_cnt); end
  endtask

  task automatic test_gap();
    logic [35:0] e;
    push_exp(4);
    run_load(5'd4, 2, 5, -1);
    n_checks++; if (obs_addr.size() != 4) begin n_fail++; $display("FAIL gap_nwrites got %0d want 4", obs_addr.size()); end
    while (exp_q.size() > 0 && obs_addr.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({obs_addr[0], obs_data[0]} !== e) begin n_fail++; $display("FAIL gap_write got %h/%h want %h/%h", obs_addr[0], obs_data[0], e[35:32], e[31:0]); end
      void'(obs_addr.pop_front()); void'(obs_data.pop_front());
    end
    n_checks++; if (gap_rdy != 3) begin n_fail++; $display("FAIL gap_ready_idle got %0d want 3", gap_rdy); end
    n_checks++; if (done_cyc != 10 || done_cnt != 1) begin n_fail++; $display("FAIL gap_done got cyc %0d cnt %0d want 10 1", done_cyc, done_cnt); end
  endtask

  task automatic test_zero();
    run_load(5'd0, 1, 0, -1);
    n_checks++; if (done_cyc != 1 || done_cnt != 1) begin n_fail++; $display("FAIL zero_done got cyc %0d cnt %0d want 1 1", done_cyc, done_cnt); end
    n_checks++; if (we_cnt != 0) begin n_fail++; $display("FAIL zero_writes got %0d want 0", we_cnt); end
    n_checks++; if (rdy_cnt != 0 || taken != 0) begin n_fail++; $display("FAIL zero_ready got rdy %0d taken %0d want 0 0", rdy_cnt, taken); end
    n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL zero_busy_after got %b want 0", busy_after); end
  endtask

  task automatic test_clamp();
    logic [35:0] e;
    push_exp(16);
    run_load(5'd20, 10, 0, -1);
    n_checks++; if (obs_addr.size() != 16) begin n_fail++; $display("FAIL clamp_nwrites got %0d want 16", obs_addr.size()); end
    while (exp_q.size() > 0 && obs_addr.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({obs_addr[0], obs_data[0]} !== e) begin n_fail++; $display("FAIL clamp_write got %h/%h want %h/%h", obs_addr[0], obs_data[0], e[35:32], e[31:0]); end
      void'(obs_addr.pop_front()); void'(obs_data.pop_front());
    end
    n_checks++; if (taken != 8) begin n_fail++; $display("FAIL clamp_beats got %0d want 8", taken); end
    n_checks++; if (done_cyc != 25 || done_cnt != 1) begin n_fail++; $display("FAIL clamp_done got cyc %0d cnt %0d want 25 1", done_cyc, done_cnt); end
  endtask

  task automatic test_start_busy();
    logic [35:0] e;
    push_exp(4);
    run_load(5'd4, 2, 0, 3);
    n_checks++; if (obs_addr.size() != 4) begin n_fail++; $display("FAIL busy_start_nwrites got %0d want 4", obs_addr.size()); end
    while (exp_q.size() > 0 && obs_addr.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({obs_addr[0], obs_data[0]} !== e) begin n_fail++; $display("FAIL busy_start_write got %h/%h want %h/%h", obs_addr[0], obs_data[0], e[35:32], e[31:0]); end
      void'(obs_addr.pop_front()); void'(obs_data.pop_front());
    end
    n_checks++; if (done_cyc != 7 || done_cnt != 1) begin n_fail++; $display("FAIL busy_start_done got cyc %0d cnt %0d want 7 1", done_cyc, done_cnt); end
  endtask

  task automatic test_reset_midload();
    logic [35:0] e;
    logic found;
    int extra_done;
    found = 0; extra_done = 0;
    @(posedge clk); #1;
    start = 1; word_count = 5'd4; s_valid = 1; s_data = mk_beat(0);
    @(posedge clk); #1;
    start = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ram_write_enable && ram_write_address == 4'd1) begin found = 1; break; end
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL midrst_reach_addr1 got %b want 1", found); end
    rst = 1;
    #1;
    n_checks++;
    if ({s_ready, busy, ram_write_enable, load_done, ram_write_address, ram_input_data} !== 40'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs got rdy=%b busy=%b we=%b done=%b addr=%h data=%h want all 0",
               s_ready, busy, ram_write_enable, load_done, ram_write_address, ram_input_data);
    end
    s_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    repeat (5) begin
      @(negedge clk);
      if (load_done) extra_done++;
    end
    n_checks++; if (extra_done != 0) begin n_fail++; $display("FAIL midrst_no_done got %0d pulses want 0", extra_done); end
    push_exp(2);
    run_load(5'd2, 1, 0, -1);
    n_checks++; if (obs_addr.size() != 2) begin n_fail++; $display("FAIL midrst_nwrites got %0d want 2", obs_addr.size()); end
    while (exp_q.size() > 0 && obs_addr.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({obs_addr[0], obs_data[0]} !== e) begin n_fail++; $display("FAIL midrst_write got %h/%h want %h/%h", obs_addr[0], obs_data[0], e[35:32], e[31:0]); end
      void'(obs_addr.pop_front()); void'(obs_data.pop_front());
    end
    n_checks++; if (done_cyc != 4 || done_cnt != 1) begin n_fail++; $display("FAIL midrst_done got cyc %0d cnt %0d want 4 1", done_cyc, done_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_truncate();
    test_gap();
    test_zero();
    test_clamp();
    test_start_busy();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
